// File: rtl/prbs_checker.sv
// Receive-side checker for the Galois LFSR sequence generator: self-synchronises
// on the received word stream, tracks lock, and counts mismatching words while locked.
module prbs_checker #(
  parameter int WIDTH         = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 3,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         taps,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         seq_in,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] LOSS_TGT = BW'(LOSS_COUNT);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                   state_reg;
  logic [WIDTH-1:0]         ref_reg;
  logic [GW-1:0]            good_cnt_reg;
  logic [BW-1:0]            bad_cnt_reg;
  logic                     locked_reg;
  logic                     err_pulse_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg;

  logic [WIDTH-1:0] expected;
  logic             fb;
  logic             match;
  logic [GW-1:0]    good_inc;
  logic [BW-1:0]    bad_inc;
  logic             unused_tap;

  // The NOR term splices the all-zero word into the cycle, so f(0) is defined.
  assign fb          = ref_reg[WIDTH-1] ^ ~(|ref_reg[WIDTH-2:0]);
  assign expected[0] = fb;
  assign unused_tap  = taps[WIDTH-1];

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_next
      assign expected[gi] = ref_reg[gi-1] ^ (taps[gi-1] & fb);
    end
  endgenerate

  assign match    = (seq_in == expected);
  assign good_inc = good_cnt_reg + 1'b1;
  assign bad_inc  = bad_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SEED;
      ref_reg       <= '0;
      good_cnt_reg  <= '0;
      bad_cnt_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (clear) begin
        state_reg     <= SEED;
        ref_reg       <= '0;
        good_cnt_reg  <= '0;
        bad_cnt_reg   <= '0;
        locked_reg    <= 1'b0;
        err_count_reg <= '0;
      end else if (in_valid) begin
        case (state_reg)
          SEED: begin
            ref_reg      <= seq_in;
            good_cnt_reg <= '0;
            state_reg    <= HUNT;
          end
          HUNT: begin
            ref_reg <= seq_in;
            if (match) begin
              if (good_inc == LOCK_TGT) begin
                state_reg    <= LOCKED;
                locked_reg   <= 1'b1;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
              end else begin
                good_cnt_reg <= good_inc;
              end
            end else begin
              good_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              ref_reg     <= seq_in;
              bad_cnt_reg <= '0;
            end else begin
              err_pulse_reg <= 1'b1;
              if (err_count_reg != {ERR_CNT_WIDTH{1'b1}})
                err_count_reg <= err_count_reg + 1'b1;
              if (bad_inc == LOSS_TGT) begin
                // Too many consecutive misses: resynchronise from the received word.
                state_reg    <= HUNT;
                locked_reg   <= 1'b0;
                ref_reg      <= seq_in;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
              end else begin
                ref_reg     <= expected;
                bad_cnt_reg <= bad_inc;
              end
            end
          end
          default: begin
            state_reg  <= SEED;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, loss, valid gaps,
// counter saturation with clear, and asynchronous reset while locked.
module tb_prbs_checker;

  localparam logic [7:0] TAPS = 8'h1D;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [7:0]  taps;
  logic        in_valid;
  logic [7:0]  seq_in;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        locked_s;
  logic        err_pulse_s;
  logic [3:0]  err_count_s;

  int checks = 0;
  int errors = 0;
  logic [7:0] g;

  prbs_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .taps(taps), .in_valid(in_valid),
    .seq_in(seq_in), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .taps(taps), .in_valid(in_valid),
    .seq_in(seq_in), .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator stimulus: shift-left form of the NOR-spliced Galois LFSR.
  function automatic logic [7:0] nxt(input logic [7:0] r);
    logic       fbit;
    logic [7:0] s;
    fbit = r[7] ^ (r[6:0] == 7'd0);
    s = {r[6:0], 1'b0};
    if (fbit) s = s ^ {TAPS[6:0], 1'b0} ^ 8'h01;
    return s;
  endfunction

  task automatic step(input logic v, input logic [7:0] w);
    in_valid = v;
    seq_in   = w;
    @(posedge clk);
    #1;
    $display("tx valid=%0d clr=%0d in=%h locked=%0d pulse=%0d cnt=%0d sat=%0d",
             v, clear, w, locked, err_pulse, err_count, err_count_s);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; taps = TAPS; in_valid = 1'b0; seq_in = 8'h00;
    #12;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", err_pulse); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 8'h5A);
  endtask

  task automatic test_lock_acquire;
    logic [7:0] words [5];
    logic       exp_lock;
    words = '{8'h00, 8'h3B, 8'h76, 8'hEC, 8'hE3};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, words[i]);
      exp_lock = (i == 4);
      checks++; if (locked !== exp_lock) begin errors++; $display("FAIL lock_acq_locked word=%0d got=%b exp=%b", i, locked, exp_lock); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL lock_acq_pulse word=%0d got=%b exp=0", i, err_pulse); end
    end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL lock_acq_count got=%0d exp=0", err_count); end
    g = 8'hE3;
  endtask

  task automatic test_single_error;
    g = nxt(g);
    step(1'b1, g ^ 8'h01);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%b exp=1", err_pulse); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%b exp=1", locked); end
    for (int i = 0; i < 3; i++) begin
      g = nxt(g);
      step(1'b1, g);
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_after_pulse i=%0d got=%b exp=0", i, err_pulse); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_after_count i=%0d got=%0d exp=1", i, err_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_after_locked i=%0d got=%b exp=1", i, locked); end
    end
  endtask

  task automatic test_valid_gaps;
    logic [8:0] pattern [9];
    int         nvalid;
    logic       exp_lock;
    clear = 1'b1;
    g = nxt(g);
    step(1'b1, g);
    clear = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL gap_clear_locked got=%b exp=0", locked); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL gap_clear_count got=%0d exp=0", err_count); end
    // Bit 8 = valid; gaps carry garbage words.
    pattern = '{9'h100, 9'h0A5, 9'h100, 9'h0FF, 9'h03C, 9'h100, 9'h100, 9'h0C3, 9'h100};
    nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      if (pattern[i][8]) begin
        g = nxt(g);
        step(1'b1, g);
        nvalid++;
      end else begin
        step(1'b0, pattern[i][7:0]);
      end
      exp_lock = (nvalid == 5);
      checks++; if (locked !== exp_lock) begin errors++; $display("FAIL gap_locked step=%0d got=%b exp=%b", i, locked, exp_lock); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL gap_pulse step=%0d got=%b exp=0", i, err_pulse); end
    end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL gap_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_loss_of_lock;
    logic [15:0] exp_cnt;
    logic        exp_lock;
    for (int i = 1; i <= 3; i++) begin
      g = nxt(g);
      step(1'b1, g ^ 8'h55);
      exp_cnt  = 16'(i);
      exp_lock = (i < 3);
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse i=%0d got=%b exp=1", i, err_pulse); end
      checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL loss_count i=%0d got=%0d exp=%0d", i, err_count, exp_cnt); end
      checks++; if (locked !== exp_lock) begin errors++; $display("FAIL loss_locked i=%0d got=%b exp=%b", i, locked, exp_lock); end
    end
    for (int i = 0; i < 5; i++) begin
      g = nxt(g);
      step(1'b1, g);
      exp_lock = (i == 4);
      checks++; if (locked !== exp_lock) begin errors++; $display("FAIL relock_locked i=%0d got=%b exp=%b", i, locked, exp_lock); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL relock_pulse i=%0d got=%b exp=0", i, err_pulse); end
    end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL relock_count got=%0d exp=3", err_count); end
  endtask

  task automatic test_saturation_clear;
    logic [3:0]  exp_sat;
    logic [15:0] exp_main;
    for (int k = 1; k <= 20; k++) begin
      g = nxt(g);
      step(1'b1, g ^ 8'h01);
      exp_sat  = (3 + k > 15) ? 4'hF : 4'(3 + k);
      exp_main = 16'(3 + k);
      checks++; if (err_count_s !== exp_sat) begin errors++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, err_count_s, exp_sat); end
      checks++; if (err_count !== exp_main) begin errors++; $display("FAIL sat_main_count k=%0d got=%0d exp=%0d", k, err_count, exp_main); end
      checks++; if (locked_s !== 1'b1) begin errors++; $display("FAIL sat_locked k=%0d got=%b exp=1", k, locked_s); end
      g = nxt(g);
      step(1'b1, g);
      checks++; if (err_pulse_s !== 1'b0) begin errors++; $display("FAIL sat_good_pulse k=%0d got=%b exp=0", k, err_pulse_s); end
    end
    clear = 1'b1;
    g = nxt(g);
    step(1'b1, g);
    clear = 1'b0;
    checks++; if (locked_s !== 1'b0) begin errors++; $display("FAIL clr_locked got=%b exp=0", locked_s); end
    checks++; if (err_count_s !== 4'd0) begin errors++; $display("FAIL clr_count got=%0d exp=0", err_count_s); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clr_main_count got=%0d exp=0", err_count); end
    checks++; if (err_pulse_s !== 1'b0) begin errors++; $display("FAIL clr_pulse got=%b exp=0", err_pulse_s); end
    for (int i = 0; i < 5; i++) begin
      g = nxt(g);
      step(1'b1, g);
      checks++; if (locked_s !== (i == 4)) begin errors++; $display("FAIL clr_relock i=%0d got=%b exp=%b", i, locked_s, (i == 4)); end
    end
  endtask

  task automatic test_async_reset;
    g = nxt(g);
    step(1'b1, g ^ 8'h01);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL arst_pre_count got=%0d exp=1", err_count); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got=%b exp=0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL arst_pulse got=%b exp=0", err_pulse); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", err_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    g = 8'hA5;
    step(1'b1, g);
    for (int i = 0; i < 4; i++) begin
      g = nxt(g);
      step(1'b1, g);
      checks++; if (locked !== (i == 3)) begin errors++; $display("FAIL arst_relock i=%0d got=%b exp=%b", i, locked, (i == 3)); end
    end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL arst_relock_count got=%0d exp=0", err_count); end
  endtask

  initial begin
    test_reset;
    test_lock_acquire;
    test_single_error;
    test_valid_gaps;
    test_loss_of_lock;
    test_saturation_clear;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side checker for the team's Galois LFSR sequence generator.
- Consumes the generator's full-state output word stream and self-synchronises from the received words.
- Declares lock after a run of correct predictions.
- While locked, counts mismatching words, flywheels through errors, and drops lock after a run of consecutive mismatches.
- Sits at the far end of a link or datapath under test, for BIST and link validation.

Parameters:
- WIDTH, 8: sequence word width; must match the generator (>= 3).
- LOCK_COUNT, 4: consecutive correct predictions required to enter LOCKED (>= 1).
- LOSS_COUNT, 3: consecutive mismatches in LOCKED that force re-hunt (>= 1).
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear: return to SEED, zero all counters.
- taps  in  WIDTH  feedback tap array, same value as the generator; static except across clear.
- in_valid  in  1  seq_in is valid this cycle.
- seq_in  in  WIDTH  received sequence word.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word while LOCKED.
- err_count  out  ERR_CNT_WIDTH  saturating count of mismatches while LOCKED.

Behaviour:
- Next-state function f(r), combinational:
  - fb = r[WIDTH-1] XOR NOR(r[WIDTH-2:0]).
  - f[0] = fb.
  - For n = 1..WIDTH-1: f[n] = r[n-1] XOR (taps[n-1] AND fb).
  - taps[WIDTH-1] is unused.
- Internal registers:
  - ref (WIDTH): last reference word.
  - good_cnt: counts to LOCK_COUNT.
  - bad_cnt: counts to LOSS_COUNT.
  - state: SEED, HUNT or LOCKED.
- Reset (async): state = SEED, ref = 0, good_cnt = 0, bad_cnt = 0, locked = 0, err_pulse = 0, err_count = 0.
- All actions below occur only on cycles with in_valid = 1. Cycles with in_valid = 0 hold all state, and err_pulse = 0 on the following cycle.
- SEED:
  - ref <= seq_in, good_cnt <= 0, go to HUNT.
- HUNT:
  - If seq_in == f(ref), good_cnt <= good_cnt + 1; otherwise good_cnt <= 0.
  - ref <= seq_in unconditionally.
  - When the increment reaches LOCK_COUNT: go to LOCKED, bad_cnt <= 0.
  - Mismatches in HUNT are never counted and never pulse err_pulse.
- LOCKED, with expected = f(ref):
  - Match: ref <= seq_in, bad_cnt <= 0.
  - Mismatch:
    - err_pulse <= 1 for exactly one cycle.
    - err_count <= err_count + 1, saturating at all-ones.
    - ref <= expected (flywheel; a single corrupted word produces exactly one error).
    - bad_cnt <= bad_cnt + 1.
  - If bad_cnt + 1 reaches LOSS_COUNT: go to HUNT, ref <= seq_in, good_cnt <= 0.
  - err_count is not cleared on loss of lock.
- Outputs are registered:
  - locked rises the cycle after the LOCK_COUNT-th matching word is sampled.
  - locked falls the cycle after the LOSS_COUNT-th consecutive mismatch is sampled.
  - err_pulse and err_count update the cycle after the offending word is sampled.
- clear:
  - Has priority over in_valid; the word presented in the same cycle is discarded.
  - Next cycle: state = SEED, all counters 0, locked = 0, err_pulse = 0.
- The all-zero word is a legal sequence member (NOR term): f(0) = {taps[WIDTH-2:0], 1}. It must be predicted and accepted like any other word.
- Changing taps while not in SEED gives undefined lock behaviour. Software must pulse clear after changing taps.

Test Plan:
- Lock acquisition: WIDTH=8, taps=8'h1D, after reset stream 0x00, 0x3B, 0x76, 0xEC, 0xE3 with in_valid=1 -> locked rises the cycle after 0xE3 is sampled; err_count = 0; err_pulse never asserts.
- Single-bit error: locked, replace one expected word with its bit-0-flipped value, then continue the correct stream -> exactly one err_pulse cycle; err_count = 1; locked stays 1; following words match.
- Loss of lock: locked, inject 3 consecutive wrong words -> err_count = 3; locked falls after the 3rd; re-lock after a further 1 seed word + 4 correct words.
- Valid gaps: interleave in_valid=0 cycles (seq_in = garbage) into a correct stream -> no errors; lock timing counts only valid words.
- Saturation and clear: ERR_CNT_WIDTH=4, force 20 errors while keeping lock (alternate good/bad words) -> err_count holds 15; pulse clear with in_valid=1 -> next cycle locked=0, err_count=0, state SEED.
- Async reset mid-lock: assert rst_n=0 between clock edges while locked -> locked, err_pulse and err_count go to 0 immediately; after release, the checker relocks from a fresh stream.
